// File: rtl/zeroheti_irq_gateway_pkg.sv
// Shared definitions for the zeroheti interrupt path: core configuration and
// per-line trigger mode.
package zeroheti_pkg;

  typedef struct packed {
    int unsigned num_irqs;
    int unsigned prio_bits;
  } core_cfg_t;

  localparam core_cfg_t DefaultCfg = '{num_irqs: 64, prio_bits: 4};

  typedef enum logic [0:0] {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } trig_mode_e;

endpackage

// File: rtl/zeroheti_irq_gateway_if.sv
// Bundle between raw interrupt sources / controller ack snoop and the gateway.
// master drives raw lines and the ack pair; slave is the gateway itself.
interface zeroheti_irq_gateway_if #(
  parameter int unsigned NrIrqs   = 64,
  parameter int unsigned IrqWidth = $clog2(NrIrqs)
);
  logic [NrIrqs-1:0]   irqs_raw_i;
  logic [IrqWidth-1:0] irq_id_i;
  logic                irq_ack_i;
  logic [NrIrqs-1:0]   ext_irqs_o;
  logic [NrIrqs-1:0]   irq_lost_o;

  modport master (
    output irqs_raw_i, irq_id_i, irq_ack_i,
    input  ext_irqs_o, irq_lost_o
  );

  modport slave (
    input  irqs_raw_i, irq_id_i, irq_ack_i,
    output ext_irqs_o, irq_lost_o
  );
endinterface

// File: rtl/zeroheti_irq_gateway_line.sv
// One interrupt line: synchroniser, stability filter, and either a level
// pass-through or a rising-edge pending latch cleared by the controller's ack.
module zeroheti_irq_gateway_line #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FilterLen  = 4,
  parameter bit          IsEdge     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic clr_i,
  output logic req_o,
  output logic lost_o
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  sync_s;
  logic                  filt;

  assign sync_d = {sync_q[SyncStages-2:0], raw_i};
  assign sync_s = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  if (FilterLen > 0) begin : g_filt
    localparam int unsigned    CntW   = $clog2(FilterLen + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FilterLen - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;

    // The counter only runs while the synchronised value disagrees with the
    // accepted one, so any agreement restarts the stability window.
    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_s != filt_q) begin
        if (cnt_q == CntMax) begin
          filt_d = sync_s;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign filt = filt_q;
  end else begin : g_nofilt
    assign filt = sync_s;
  end

  if (IsEdge) begin : g_edge
    logic prev_q, pend_q, lost_q;
    logic prev_d, pend_d, lost_d;
    logic rise;

    // A new edge coinciding with an ack re-arms the line rather than being lost.
    assign rise   = filt & ~prev_q;
    assign prev_d = filt;
    assign pend_d = rise | (pend_q & ~clr_i);
    assign lost_d = rise & pend_q & ~clr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
        pend_q <= 1'b0;
        lost_q <= 1'b0;
      end else begin
        prev_q <= prev_d;
        pend_q <= pend_d;
        lost_q <= lost_d;
      end
    end

    assign req_o  = pend_q;
    assign lost_o = lost_q;
  end else begin : g_level
    logic unused_clr;
    assign unused_clr = clr_i;
    assign req_o      = filt;
    assign lost_o     = 1'b0;
  end

endmodule

// File: rtl/zeroheti_irq_gateway.sv
// Conditions raw external interrupts into level requests for the controller;
// edge lines stay pending until the controller acks their ID.
module zeroheti_irq_gateway
  import zeroheti_pkg::*;
#(
  parameter core_cfg_t                     CoreCfg    = DefaultCfg,
  parameter int unsigned                   SyncStages = 2,
  parameter int unsigned                   FilterLen  = 4,
  parameter logic [CoreCfg.num_irqs-1:0]   EdgeMask   = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  zeroheti_irq_gateway_if.slave  bus
);

  localparam int unsigned NrIrqs   = CoreCfg.num_irqs;
  localparam int unsigned IrqWidth = $clog2(NrIrqs);

  logic [NrIrqs-1:0] clr;
  logic [NrIrqs-1:0] req;
  logic [NrIrqs-1:0] lost;

  for (genvar i = 0; i < NrIrqs; i++) begin : g_line
    localparam trig_mode_e Mode = EdgeMask[i] ? TRIG_EDGE : TRIG_LEVEL;

    // IDs outside the line range match no line and are dropped here.
    assign clr[i] = bus.irq_ack_i && (bus.irq_id_i == IrqWidth'(i));

    zeroheti_irq_gateway_line #(
      .SyncStages (SyncStages),
      .FilterLen  (FilterLen),
      .IsEdge     (Mode == TRIG_EDGE)
    ) u_line (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (bus.irqs_raw_i[i]),
      .clr_i  (clr[i]),
      .req_o  (req[i]),
      .lost_o (lost[i])
    );
  end

  assign bus.ext_irqs_o = req;
  assign bus.irq_lost_o = lost;

endmodule

// File: doc/zeroheti_irq_gateway.md
Name: zeroheti_irq_gateway

Overview:
- Input conditioning stage directly upstream of the core interrupt controller.
- Takes raw, asynchronous external interrupt lines and synchronises and deglitches each one.
- Converts each line to the controller's level-sensitive request format: level lines pass through; edge lines are latched as pending until the controller acknowledges that ID.
- Its output drives the controller's ext_irqs_i; it snoops the controller's irq_id_i/irq_ack_i pair to clear latched edges.

Parameters:
- CoreCfg, zeroheti_pkg::DefaultCfg, core configuration; NrIrqs = CoreCfg.num_irqs, IrqWidth = $clog2(NrIrqs) are derived localparams.
- SyncStages, 2, synchroniser flop depth per line; legal range 2..4.
- FilterLen, 4, consecutive stable cycles required before a filtered line changes; 0 bypasses the filter.
- EdgeMask, '0 (NrIrqs bits), per-line trigger mode; bit=1 means rising-edge, bit=0 means active-high level.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- irqs_raw_i  in  NrIrqs  raw asynchronous interrupt sources.
- irq_id_i  in  IrqWidth  ID being acknowledged by the controller/core.
- irq_ack_i  in  1  acknowledge strobe, valid for one cycle.
- ext_irqs_o  out  NrIrqs  conditioned requests to the controller.
- irq_lost_o  out  NrIrqs  one-cycle pulse per line: an edge arrived while that line was already pending.

Behaviour:
- One clock domain; reset is asynchronous, active-low, on rst_ni.
- Reset value of all state and outputs is 0: sync flops, filter counters, filtered values, previous values, pending bits, ext_irqs_o, irq_lost_o.
- Reset asserted mid-operation discards all pending edges. After deassertion, nothing is re-detected until the synchronised input is seen high and the filter accepts it.
- Synchroniser: SyncStages flops per line, no logic between stages; s[i] is the last stage.
- Filter, FilterLen>0:
  - Each line has a counter of width $clog2(FilterLen+1) and a registered value f[i].
  - When s[i]==f[i], the counter clears to 0.
  - When s[i]!=f[i] and the counter == FilterLen-1, f[i] takes s[i] and the counter clears.
  - Otherwise, when s[i]!=f[i], the counter increments.
  - Any glitch shorter than FilterLen synchronised cycles is suppressed.
- Filter, FilterLen==0: f[i] = s[i] combinationally, no counter.
- Level line (EdgeMask[i]=0):
  - ext_irqs_o[i] = f[i].
  - Acks for this ID are ignored; irq_lost_o[i] stays 0.
- Edge line (EdgeMask[i]=1):
  - Keep prev[i] = f[i] delayed one cycle; rise[i] = f[i] & ~prev[i].
  - clr[i] = irq_ack_i & (irq_id_i == i).
  - Next pending[i] = rise[i] | (pending[i] & ~clr[i]). On a simultaneous rise and ack, the new edge wins and pending stays 1.
  - ext_irqs_o[i] = pending[i] (registered).
  - irq_lost_o[i] registers rise[i] & pending[i] & ~clr[i].
- Acks with irq_id_i >= NrIrqs are ignored.
- Latency, raw input rising at a clock edge and held stable:
  - s[i] reflects it after SyncStages cycles.
  - Level output rises after SyncStages+FilterLen cycles.
  - Edge pending/output rises after SyncStages+FilterLen+1 cycles.
  - Falling input: the level output falls after the same level latency; the edge output is unaffected.
- The filter counter never exceeds FilterLen-1; there is no wrap-around.
- Only rising edges set pending; a falling f[i] has no effect on edge lines.

Decomposition:
- Shared package zeroheti_pkg holds trig_mode_e (TRIG_LEVEL, TRIG_EDGE); the core_cfg_t fields are reused.
- There are no new shared constants.
- One natural sub-module, zeroheti_irq_gateway_line: synchroniser, filter, edge/pending logic for a single line.
  - Parameters: SyncStages, FilterLen, IsEdge.
  - The top instantiates it NrIrqs times in a generate loop and performs the ID decode for clr.

Test Plan:
All scenarios use NrIrqs=64, SyncStages=2, FilterLen=4, EdgeMask[3]=1 and all other bits 0.
- Line 0 raw goes 0->1 at cycle 0 and is held -> ext_irqs_o[0]=1 from cycle 6. Raw returns to 0 at cycle 20 -> ext_irqs_o[0]=0 from cycle 26.
- Line 0 raw high for 3 cycles only -> ext_irqs_o[0] never rises; counter returns to 0.
- Line 3 raw rises at cycle 0, falls at cycle 10 -> ext_irqs_o[3]=1 from cycle 7 and stays 1. Ack with irq_id_i=3 at cycle 30 -> ext_irqs_o[3]=0 at cycle 31.
- Line 3 pending, second filtered rising edge, no ack -> irq_lost_o[3] pulses exactly 1 cycle; ext_irqs_o[3] stays 1. Ack in the same cycle as a new rise -> ext_irqs_o[3] stays 1 and irq_lost_o[3]=0.
- Ack of id 0 (level line) while line 0 is high -> ext_irqs_o[0] stays 1. Ack with irq_id_i=3 while line 3 is idle -> no change.
- Line 3 pending, rst_ni pulsed low asynchronously mid-cycle -> ext_irqs_o and irq_lost_o go to 0 immediately. Raw held high through reset -> ext_irqs_o[3] rises 7 cycles after deassertion.
